action_queue: RTL and testbench

ACTION_QUEUE -- requirements
Module: action_queue

---
 rtl/action_queue.sv | 177 +++++++++++++++++
 tb/tb_action_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/action_queue.sv
// action_queue: coalescing button/timer event queue feeding a FWFT FIFO.
// Ports: clk, reset_n (async low), enable, flush, btn_* pulses, down_rst,
//   ev_valid/ev_code/ev_ready consumer handshake, count, overflow.
//   Optional bar timer enabled by defining ACTION_QUEUE_BAR_EN.
module action_queue #(
   parameter int QSIZE     = 16,
   parameter int DOWN_TICK = 75_000_000,
   parameter int BAR_TICK  = 500_000_000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic                   flush,
   input  logic                   btn_left,
   input  logic                   btn_right,
   input  logic                   btn_rotate,
   input  logic                   btn_rotate_rev,
   input  logic                   btn_drop,
   input  logic                   btn_hold,
   input  logic                   down_rst,
   output logic                   ev_valid,
   output logic [7:0]             ev_code,
   input  logic                   ev_ready,
   output logic [$clog2(QSIZE):0] count,
   output logic                   overflow
);

   localparam int AW = $clog2(QSIZE);
   localparam int CW = AW + 1;
   localparam int DW = (DOWN_TICK > 1) ? $clog2(DOWN_TICK) : 1;

   // Pending bit index doubles as arbitration priority (higher wins).
   function automatic logic [7:0] code_of(input logic [2:0] idx);
      logic [7:0] c;
      case (idx)
         3'd0:    c = 8'd6;
         3'd1:    c = 8'd5;
         3'd2:    c = 8'd4;
         3'd3:    c = 8'd10;
         3'd4:    c = 8'd9;
         3'd5:    c = 8'd8;
         3'd6:    c = 8'd7;
         default: c = 8'd11;
      endcase
      return c;
   endfunction

   logic [7:0]    mem_q [QSIZE];
   logic [7:0]    mem_d [QSIZE];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ev_valid_q, ev_valid_d;
   logic [7:0]    ev_code_q, ev_code_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    pending_q, pending_d;
   logic [DW-1:0] down_q, down_d;
   logic          down_tick;
   logic          bar_tick;
   logic [7:0]    pulse;
   logic [7:0]    clr;
   logic [2:0]    sel_idx;
   logic          pop;
   logic          wr_en;

`ifdef ACTION_QUEUE_BAR_EN
   localparam int BW = (BAR_TICK > 1) ? $clog2(BAR_TICK) : 1;
   logic [BW-1:0] bar_q, bar_d;

   always_comb begin
      bar_d    = bar_q;
      bar_tick = 1'b0;
      if (enable) begin
         if (bar_q == BW'(BAR_TICK - 1)) begin
            bar_d    = '0;
            bar_tick = 1'b1;
         end else begin
            bar_d = bar_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) bar_q <= '0;
      else          bar_q <= bar_d;
   end
`else
   logic unused_bar_tick;
   assign unused_bar_tick = ^BAR_TICK;
   assign bar_tick = 1'b0;
`endif

   // Gravity: down_rst wins over a coincident terminal count.
   always_comb begin
      down_d    = down_q;
      down_tick = 1'b0;
      if (down_rst) begin
         down_d = '0;
      end else if (enable) begin
         if (down_q == DW'(DOWN_TICK - 1)) begin
            down_d    = '0;
            down_tick = 1'b1;
         end else begin
            down_d = down_q + 1'b1;
         end
      end
   end

   assign pulse = {bar_tick, btn_drop, btn_hold, btn_rotate,
                   btn_rotate_rev, btn_left, btn_right, down_tick};

   always_comb begin
      sel_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (pending_q[i]) sel_idx = 3'(i);
      end
   end

   assign pop   = ev_valid_q & ev_ready;
   assign wr_en = enable & (|pending_q) &
                  ((count_q != CW'(QSIZE)) | pop);
   assign clr   = wr_en ? (8'd1 << sel_idx) : 8'd0;

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q + AW'(wr_en);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      count_d    = count_q + CW'(wr_en) - CW'(pop);
      overflow_d = overflow_q;
      pending_d  = '0;
      if (wr_en) mem_d[wr_ptr_q] = code_of(sel_idx);
      if (enable) begin
         // A pulse on an already pending source is dropped, not re-armed.
         pending_d  = (pending_q & ~clr) | (pulse & ~pending_q);
         overflow_d = overflow_q | (|(pulse & pending_q));
      end
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         pending_d  = '0;
      end
      ev_valid_d = (count_d != '0);
      ev_code_d  = ev_valid_d ? mem_d[rd_ptr_d] : 8'd0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < QSIZE; i++) mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ev_valid_q <= 1'b0;
         ev_code_q  <= '0;
         overflow_q <= 1'b0;
         pending_q  <= '0;
         down_q     <= '0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ev_valid_q <= ev_valid_d;
         ev_code_q  <= ev_code_d;
         overflow_q <= overflow_d;
         pending_q  <= pending_d;
         down_q     <= down_d;
      end
   end

   assign ev_valid = ev_valid_q;
   assign ev_code  = ev_code_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_action_queue.sv
// tb_action_queue: directed self-checking bench for action_queue
// (QSIZE=4, DOWN_TICK=8, BAR_TICK=40).
module tb_action_queue;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic       flush = 1'b0;
   logic       btn_left = 1'b0;
   logic       btn_right = 1'b0;
   logic       btn_rotate = 1'b0;
   logic       btn_rotate_rev = 1'b0;
   logic       btn_drop = 1'b0;
   logic       btn_hold = 1'b0;
   logic       down_rst = 1'b0;
   logic       ev_valid;
   logic [7:0] ev_code;
   logic       ev_ready = 1'b0;
   logic [2:0] count;
   logic       overflow;

   int checks = 0;
   int failures = 0;

`ifdef ACTION_QUEUE_BAR_EN
   localparam int EXP_BAR = 1;
`else
   localparam int EXP_BAR = 0;
`endif

   action_queue #(.QSIZE(4), .DOWN_TICK(8), .BAR_TICK(40)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
      .btn_left(btn_left), .btn_right(btn_right),
      .btn_rotate(btn_rotate), .btn_rotate_rev(btn_rotate_rev),
      .btn_drop(btn_drop), .btn_hold(btn_hold), .down_rst(down_rst),
      .ev_valid(ev_valid), .ev_code(ev_code), .ev_ready(ev_ready),
      .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      int down_seen;
      int bar_seen;
      logic [7:0] seq_code [5];
      logic [2:0] seq_cnt [5];
      seq_code = '{8'd8, 8'd9, 8'd10, 8'd4, 8'd5};
      seq_cnt  = '{3'd4, 3'd4, 3'd3, 3'd2, 3'd1};

      // reset state
      step();
      step();
      check("rst_count", 32'(count), 0);
      check("rst_valid", 32'(ev_valid), 0);
      check("rst_code", 32'(ev_code), 0);
      check("rst_ovf", 32'(overflow), 0);

      // gravity only: DOWN valid after edges 9, 17, 25
      reset_n = 1'b1;
      enable = 1'b1;
      ev_ready = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         step();
         check($sformatf("grav_valid_%0d", k), 32'(ev_valid),
               32'((k == 9) || (k == 17) || (k == 25)));
         if (k == 9 || k == 17 || k == 25)
            check($sformatf("grav_code_%0d", k), 32'(ev_code), 6);
      end

      // hold gravity off, clear queue
      down_rst = 1'b1;
      ev_ready = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush0_count", 32'(count), 0);

      // left + drop together: drop first
      btn_left = 1'b1;
      btn_drop = 1'b1;
      step();
      btn_left = 1'b0;
      btn_drop = 1'b0;
      step();
      check("ld_first_code", 32'(ev_code), 7);
      step();
      check("ld_code", 32'(ev_code), 7);
      check("ld_count", 32'(count), 2);
      ev_ready = 1'b1;
      step();
      check("ld_second_code", 32'(ev_code), 4);
      check("ld_second_count", 32'(count), 1);
      step();
      check("ld_empty", 32'(ev_valid), 0);
      ev_ready = 1'b0;

      // six buttons at once, FIFO saturates
      btn_drop = 1'b1;
      btn_hold = 1'b1;
      btn_rotate = 1'b1;
      btn_rotate_rev = 1'b1;
      btn_left = 1'b1;
      btn_right = 1'b1;
      step();
      btn_drop = 1'b0;
      btn_hold = 1'b0;
      btn_rotate = 1'b0;
      btn_rotate_rev = 1'b0;
      btn_left = 1'b0;
      btn_right = 1'b0;
      for (int k = 0; k < 5; k++) step();
      check("sat_count", 32'(count), 4);
      check("sat_head", 32'(ev_code), 7);
      check("sat_ovf", 32'(overflow), 0);
      ev_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("drain_code_%0d", k), 32'(ev_code),
               32'(seq_code[k]));
         check($sformatf("drain_count_%0d", k), 32'(count),
               32'(seq_cnt[k]));
      end
      step();
      check("drain_empty", 32'(ev_valid), 0);
      check("drain_count", 32'(count), 0);
      ev_ready = 1'b0;

      // fill, then double rotate while held -> overflow
      btn_drop = 1'b1;
      btn_hold = 1'b1;
      btn_left = 1'b1;
      btn_right = 1'b1;
      step();
      btn_drop = 1'b0;
      btn_hold = 1'b0;
      btn_left = 1'b0;
      btn_right = 1'b0;
      for (int k = 0; k < 4; k++) step();
      check("full_count", 32'(count), 4);
      btn_rotate = 1'b1;
      step();
      btn_rotate = 1'b0;
      step();
      check("rot1_ovf", 32'(overflow), 0);
      btn_rotate = 1'b1;
      step();
      btn_rotate = 1'b0;
      check("rot2_ovf", 32'(overflow), 1);
      check("rot2_count", 32'(count), 4);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_count", 32'(count), 0);
      check("flush_valid", 32'(ev_valid), 0);
      check("flush_ovf", 32'(overflow), 0);
      check("flush_code", 32'(ev_code), 0);
      step();
      step();
      step();
      check("flush_pend_clr", 32'(ev_valid), 0);

      // enable low ignores pulses
      enable = 1'b0;
      btn_left = 1'b1;
      step();
      btn_left = 1'b0;
      step();
      step();
      check("dis_valid", 32'(ev_valid), 0);
      check("dis_count", 32'(count), 0);
      enable = 1'b1;
      step();
      check("dis_after", 32'(ev_valid), 0);

      // reset mid-transfer with three queued
      btn_drop = 1'b1;
      btn_hold = 1'b1;
      btn_left = 1'b1;
      step();
      btn_drop = 1'b0;
      btn_hold = 1'b0;
      btn_left = 1'b0;
      step();
      step();
      step();
      check("pre_rst_count", 32'(count), 3);
      down_rst = 1'b0;
      ev_ready = 1'b1;
      reset_n = 1'b0;
      #1;
      check("async_valid", 32'(ev_valid), 0);
      check("async_count", 32'(count), 0);
      step();
      reset_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         check($sformatf("post_rst_quiet_%0d", k), 32'(ev_valid), 0);
      end
      step();
      check("post_rst_down_valid", 32'(ev_valid), 1);
      check("post_rst_down_code", 32'(ev_code), 6);

      // down_rst every 5 cycles: no DOWN; BAR only when enabled
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      down_seen = 0;
      bar_seen = 0;
      for (int i = 0; i < 60; i++) begin
         down_rst = (i % 5 == 4);
         step();
         if (ev_valid && ev_code == 8'd6) down_seen++;
         if (ev_valid && ev_code == 8'd11) bar_seen++;
      end
      down_rst = 1'b0;
      check("dr_no_down", 32'(down_seen), 0);
      check("dr_bar", 32'(bar_seen), 32'(EXP_BAR));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
